// File: rtl/cc_execute_stage_pkg.sv
// Shared constants for the execute stage: instruction codes, condition selectors
// and the bit positions of the flags inside the packed condition-code word.
package cc_execute_stage_pkg;

    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_e;

    // Packed condition-code word is {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

endpackage

// File: rtl/cc_execute_stage_cond_eval.sv
// Combinational branch/cmov condition evaluation from a flag set and a function code.
module cond_eval
    import cc_execute_stage_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt;

    always_comb begin
        lt  = sf ^ of;
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_execute_stage.sv
// Execute stage: condition-code register, branch condition and the E/M pipeline register.
module cc_execute_stage
    import cc_execute_stage_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100,
    parameter logic [3:0] OPQ_CODE = I_OPQ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_ans,
    input  logic             alu_overflow,
    input  logic             in_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic             cc_block,
    input  logic             stall,
    input  logic             bubble,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             cnd,
    output logic [WIDTH-1:0] m_valE,
    output logic             m_cnd,
    output logic             m_valid
);

    logic [2:0]       cc_reg;
    logic [2:0]       cc_next;
    logic             set_cc;
    logic [WIDTH-1:0] m_vale_reg;
    logic             m_cnd_reg;
    logic             m_valid_reg;

    assign set_cc = in_valid & (icode == OPQ_CODE) & ~cc_block & ~stall & ~bubble;

    always_comb begin
        cc_next        = cc_reg;
        cc_next[CC_ZF] = (alu_ans == '0);
        cc_next[CC_SF] = alu_ans[WIDTH-1];
        cc_next[CC_OF] = alu_overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_reg <= CC_RESET;
        end else if (set_cc) begin
            cc_reg <= cc_next;
        end
    end

    assign cc_zf = cc_reg[CC_ZF];
    assign cc_sf = cc_reg[CC_SF];
    assign cc_of = cc_reg[CC_OF];

    // Evaluated on the flags held before this instruction updates them
    cond_eval u_cond_eval (
        .ifun (ifun),
        .zf   (cc_zf),
        .sf   (cc_sf),
        .of   (cc_of),
        .cnd  (cnd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_vale_reg  <= '0;
            m_cnd_reg   <= 1'b0;
            m_valid_reg <= 1'b0;
        end else if (stall) begin
            m_vale_reg  <= m_vale_reg;
            m_cnd_reg   <= m_cnd_reg;
            m_valid_reg <= m_valid_reg;
        end else if (bubble) begin
            m_vale_reg  <= '0;
            m_cnd_reg   <= 1'b0;
            m_valid_reg <= 1'b0;
        end else begin
            m_vale_reg  <= in_valid ? alu_ans : '0;
            m_cnd_reg   <= cnd;
            m_valid_reg <= in_valid;
        end
    end

    assign m_valE  = m_vale_reg;
    assign m_cnd   = m_cnd_reg;
    assign m_valid = m_valid_reg;

endmodule

// File: tb/tb_cc_execute_stage.sv
// Directed-vector bench for cc_execute_stage: one vector per clock, checks cnd
// before the edge and the registered flags/E-M outputs after it.
module tb_cc_execute_stage;

    localparam logic [3:0]  OP  = 4'h6;
    localparam logic [3:0]  JX  = 4'h7;
    localparam logic [63:0] NEG5 = 64'hFFFF_FFFF_FFFF_FFFB;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] alu_ans;
    logic        alu_overflow;
    logic        in_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        cc_block;
    logic        stall;
    logic        bubble;
    logic        cc_zf, cc_sf, cc_of, cnd;
    logic [63:0] m_valE;
    logic        m_cnd, m_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_execute_stage dut (
        .clk          (clk),
        .rst          (rst),
        .alu_ans      (alu_ans),
        .alu_overflow (alu_overflow),
        .in_valid     (in_valid),
        .icode        (icode),
        .ifun         (ifun),
        .cc_block     (cc_block),
        .stall        (stall),
        .bubble       (bubble),
        .cc_zf        (cc_zf),
        .cc_sf        (cc_sf),
        .cc_of        (cc_of),
        .cnd          (cnd),
        .m_valE       (m_valE),
        .m_cnd        (m_cnd),
        .m_valid      (m_valid)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  ic;
        logic [3:0]  ifn;
        logic        blk;
        logic        stl;
        logic        bub;
        logic [63:0] ans;
        logic        ovf;
        logic        chk_cnd;
        logic        cnd;
        logic        zf;
        logic        sf;
        logic        of;
        logic [63:0] vale;
        logic        mcnd;
        logic        mvalid;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        in_valid     = v.iv;
        icode        = v.ic;
        ifun         = v.ifn;
        cc_block     = v.blk;
        stall        = v.stl;
        bubble       = v.bub;
        alu_ans      = v.ans;
        alu_overflow = v.ovf;
    endtask

    initial begin
        //          rst iv ic  ifn  blk stl bub ans      ovf chk cnd zf sf of vale     mcnd mvalid
        vec[0]  = '{1, 0, 0,  0,   0,  0,  0,  64'h0,   0,  0,  0,  1, 0, 0, 64'h0,   0,   0};
        vec[1]  = '{1, 0, 0,  3,   0,  0,  0,  64'h0,   0,  1,  1,  1, 0, 0, 64'h0,   0,   0};
        vec[2]  = '{0, 1, OP, 0,   0,  0,  0,  64'h0,   0,  1,  1,  1, 0, 0, 64'h0,   1,   1};
        vec[3]  = '{0, 1, OP, 0,   0,  0,  0,  NEG5,    0,  1,  1,  0, 1, 0, NEG5,    1,   1};
        vec[4]  = '{0, 1, JX, 2,   0,  0,  0,  64'h10,  0,  1,  1,  0, 1, 0, 64'h10,  1,   1};
        vec[5]  = '{0, 1, JX, 5,   0,  0,  0,  64'h20,  0,  1,  0,  0, 1, 0, 64'h20,  0,   1};
        vec[6]  = '{0, 1, OP, 0,   0,  0,  0,  MINV,    1,  1,  1,  0, 1, 1, MINV,    1,   1};
        vec[7]  = '{0, 1, JX, 2,   0,  0,  0,  64'h30,  0,  1,  0,  0, 1, 1, 64'h30,  0,   1};
        vec[8]  = '{0, 1, JX, 5,   0,  0,  0,  64'h40,  0,  1,  1,  0, 1, 1, 64'h40,  1,   1};
        vec[9]  = '{0, 1, OP, 0,   1,  0,  0,  64'h0,   0,  1,  1,  0, 1, 1, 64'h0,   1,   1};
        vec[10] = '{0, 1, OP, 3,   0,  1,  0,  64'h7,   0,  1,  0,  0, 1, 1, 64'h0,   1,   1};
        vec[11] = '{0, 1, OP, 0,   0,  0,  1,  64'h5,   0,  1,  1,  0, 1, 1, 64'h0,   0,   0};
        vec[12] = '{0, 1, OP, 4,   0,  0,  0,  64'h9,   0,  1,  1,  0, 0, 0, 64'h9,   1,   1};
        vec[13] = '{0, 1, OP, 3,   0,  1,  1,  64'h0,   0,  1,  0,  0, 0, 0, 64'h9,   1,   1};
        vec[14] = '{0, 0, OP, 0,   0,  0,  0,  64'h55,  0,  1,  1,  0, 0, 0, 64'h0,   1,   0};
        vec[15] = '{0, 1, OP, 3,   0,  0,  0,  64'h0,   0,  1,  0,  1, 0, 0, 64'h0,   0,   1};
        vec[16] = '{0, 1, OP, 3,   0,  0,  0,  ALL1,    0,  1,  1,  0, 1, 0, ALL1,    1,   1};
        vec[17] = '{0, 1, OP, 6,   0,  0,  0,  MINV,    1,  1,  0,  0, 1, 1, MINV,    0,   1};
        vec[18] = '{1, 1, OP, 1,   0,  0,  0,  64'h77,  0,  1,  0,  1, 0, 0, 64'h0,   0,   0};
        vec[19] = '{0, 0, 0,  8,   0,  0,  0,  64'h0,   0,  1,  0,  1, 0, 0, 64'h0,   0,   0};
        vec[20] = '{0, 0, 0,  1,   0,  0,  0,  64'h0,   0,  1,  1,  1, 0, 0, 64'h0,   1,   0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i]);
            #1;
            if (vec[i].chk_cnd) check("cnd", i, {63'b0, cnd}, {63'b0, vec[i].cnd});
            @(posedge clk);
            #1;
            check("cc", i, {61'b0, cc_zf, cc_sf, cc_of}, {61'b0, vec[i].zf, vec[i].sf, vec[i].of});
            check("m_valE", i, m_valE, vec[i].vale);
            check("m_cnd", i, {63'b0, m_cnd}, {63'b0, vec[i].mcnd});
            check("m_valid", i, {63'b0, m_valid}, {63'b0, vec[i].mvalid});
            $display("vec %0d: cc=%b%b%b cnd=%b m_valE=%h m_cnd=%b m_valid=%b",
                     i, cc_zf, cc_sf, cc_of, cnd, m_valE, m_cnd, m_valid);
        end

        // Sweep every ifun against CC={1,0,0} (left by the vectors above)
        begin
            logic [15:0] exp_zf;
            exp_zf = 16'h002B;
            @(negedge clk);
            in_valid = 1'b0; rst = 1'b0; stall = 1'b0; bubble = 1'b0;
            for (int f = 0; f < 16; f++) begin
                ifun = f[3:0];
                #1;
                check("sweep_zf_cnd", f, {63'b0, cnd}, {63'b0, exp_zf[f]});
            end
        end

        // Load CC={0,1,0} with an all-ones result, then sweep again
        begin
            logic [15:0] exp_sf;
            exp_sf = 16'h0017;
            @(negedge clk);
            in_valid = 1'b1; icode = OP; cc_block = 1'b0; alu_ans = ALL1; alu_overflow = 1'b0; ifun = 4'h0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("cc_sf_load", 0, {61'b0, cc_zf, cc_sf, cc_of}, 64'd2);
            for (int f = 0; f < 16; f++) begin
                ifun = f[3:0];
                #1;
                check("sweep_sf_cnd", f, {63'b0, cnd}, {63'b0, exp_sf[f]});
            end
            $display("sweeps done: cc=%b%b%b", cc_zf, cc_sf, cc_of);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
